// File: rtl/fifo_divmul_engine.sv
// fifo_divmul_engine: FIFO-fed signed divider returning q*r or {q,r}.
// Restoring division on magnitudes, one quotient bit per cycle.
module fifo_divmul_engine #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           write_req,
    input  logic [2*W-1:0] fifo_write_data,
    output logic           full_out,
    output logic [AW:0]    level,
    input  logic           mode,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [2*W-1:0] result,
    output logic           div_zero,
    output logic           done_sig
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_MUL,
        S_OUT
    } state_t;

    state_t state, state_nx;

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [2*W-1:0] pop_data;
    logic           push, pop;

    logic [W-1:0]   dvd_in, dvs_in, dvd_mag, dvs_mag_in;
    logic [W-1:0]   q_reg, rem_reg, dvs_mag, rem_nx;
    logic [W:0]     rem_sh;
    logic           ge;
    logic           neg_q, neg_r, zero_q, mode_q;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   q_s, r_s;
    logic signed [2*W-1:0] q_x, r_x, prod;

    assign full_out = (level == (AW+1)'(DEPTH));
    assign push     = write_req && !full_out;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pop_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    assign dvd_in     = pop_data[2*W-1:W];
    assign dvs_in     = pop_data[W-1:0];
    assign dvd_mag    = dvd_in[W-1] ? -dvd_in : dvd_in;
    assign dvs_mag_in = dvs_in[W-1] ? -dvs_in : dvs_in;

    // Dividend magnitude shifts out of q_reg as quotient bits shift in.
    assign rem_sh = {rem_reg, q_reg[W-1]};
    assign ge     = (rem_sh >= {1'b0, dvs_mag});
    assign rem_nx = ge ? W'(rem_sh - {1'b0, dvs_mag}) : rem_sh[W-1:0];

    assign q_s  = neg_q ? -q_reg : q_reg;
    assign r_s  = neg_r ? -rem_reg : rem_reg;
    assign q_x  = {{W{q_s[W-1]}}, q_s};
    assign r_x  = {{W{r_s[W-1]}}, r_s};
    assign prod = q_x * r_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (level != '0) state_nx = S_LOAD;
            S_LOAD:  state_nx = (dvs_in == '0) ? S_MUL : S_DIV;
            S_DIV:   if (cnt == CW'(W - 1)) state_nx = S_MUL;
            S_MUL:   state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        out_valid = 1'b0;
        done_sig  = 1'b0;
        unique case (state)
            S_IDLE: pop = (level != '0);
            S_OUT: begin
                out_valid = 1'b1;
                done_sig  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg    <= '0;
            rem_reg  <= '0;
            dvs_mag  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_q   <= 1'b0;
            mode_q   <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    mode_q <= mode;
                    cnt    <= '0;
                    if (dvs_in == '0) begin
                        q_reg   <= '1;
                        rem_reg <= dvd_in;
                        neg_q   <= 1'b0;
                        neg_r   <= 1'b0;
                        zero_q  <= 1'b1;
                    end else begin
                        q_reg   <= dvd_mag;
                        rem_reg <= '0;
                        dvs_mag <= dvs_mag_in;
                        neg_q   <= dvd_in[W-1] ^ dvs_in[W-1];
                        neg_r   <= dvd_in[W-1];
                        zero_q  <= 1'b0;
                    end
                end
                S_DIV: begin
                    q_reg   <= {q_reg[W-2:0], ge};
                    rem_reg <= rem_nx;
                    cnt     <= cnt + 1'b1;
                end
                S_MUL: begin
                    result   <= mode_q ? {q_s, r_s} : prod;
                    div_zero <= zero_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_divmul_engine.sv
// tb_fifo_divmul_engine: directed and random checks of the divmul engine
// against an arithmetic reference model.
module tb_fifo_divmul_engine;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b1;
    logic           write_req = 1'b0;
    logic [2*W-1:0] fifo_write_data = '0;
    logic           mode      = 1'b0;
    logic           out_ready = 1'b0;
    logic           full_out;
    logic [AW:0]    level;
    logic           out_valid;
    logic [2*W-1:0] result;
    logic           div_zero;
    logic           done_sig;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_divmul_engine #(.W(W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_req       (write_req),
        .fifo_write_data (fifo_write_data),
        .full_out        (full_out),
        .level           (level),
        .mode            (mode),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .result          (result),
        .div_zero        (div_zero),
        .done_sig        (done_sig)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed divide, wrap q/r to W bits, then combine.
    function automatic logic [2*W:0] model(input logic [2*W-1:0] w,
                                           input logic m);
        int a, b, qi, ri, p;
        logic signed [W-1:0] qs, rs;
        logic dz;
        a = int'($signed(w[2*W-1:W]));
        b = int'($signed(w[W-1:0]));
        if (b == 0) begin
            qi = -1;
            ri = a;
            dz = 1'b1;
        end else begin
            qi = a / b;
            ri = a % b;
            dz = 1'b0;
        end
        qs = qi[W-1:0];
        rs = ri[W-1:0];
        p  = int'(qs) * int'(rs);
        return m ? {dz, qs, rs} : {dz, p[2*W-1:0]};
    endfunction

    function automatic logic [2*W-1:0] rand_word(input bit nz);
        logic [W-1:0] a, b;
        int sel;
        a   = W'($urandom);
        b   = W'($urandom);
        sel = nz ? 7 : int'($urandom_range(0, 7));
        if (sel == 0) b = '0;
        else if (sel == 1) b = '1;
        else if (sel == 2) begin
            a = 8'h80;
            b = 8'hFF;
        end
        if (nz && b == '0) b = 8'd3;
        return {a, b};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                chk("idle_valid", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                chk("result", 32'(result), 32'(exp_q[0][2*W-1:0]));
                chk("div_zero", 32'(div_zero), 32'(exp_q[0][2*W]));
                chk("done_sig", 32'(done_sig), 32'(out_ready));
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("done_idle", 32'(done_sig), 32'd0);
            end
            if (done_sig) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2*W-1:0] w, input bit acc);
        write_req       = 1'b1;
        fifo_write_data = w;
        tick();
        write_req = 1'b0;
        if (acc) exp_q.push_back(model(w, mode));
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        out_ready = 1'b1;
        tick();
    endtask

    // Edges from push to the edge where out_valid is first sampled high:
    // one edge until the pop, then the engine latency.
    task automatic latency(input logic [2*W-1:0] w, input int exp_n);
        int n = 0;
        push(w, 1'b1);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        chk("latency", 32'(n), 32'(exp_n));
        tick();
    endtask

    initial begin
        int d0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done_sig), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        mode      = 1'b0;
        out_ready = 1'b1;
        d0        = done_cnt;
        push({8'd45, 8'd2}, 1'b1);
        push({8'd23, 8'd12}, 1'b1);
        drain(1'b0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd2);

        push({8'd15, 8'hFA}, 1'b1);
        drain(1'b0);
        mode = 1'b1;
        push({8'd15, 8'hFA}, 1'b1);
        drain(1'b0);

        latency({8'd7, 8'd0}, 1 + 3);
        drain(1'b0);
        mode = 1'b0;
        latency({8'd100, 8'd7}, 1 + W + 3);
        drain(1'b0);

        mode = 1'b1;
        push({8'h80, 8'hFF}, 1'b1);
        drain(1'b0);

        out_ready = 1'b0;
        mode      = 1'b0;
        for (int i = 0; i < 18; i++) push(rand_word(1'b0), i < 17);
        chk("full_level", 32'(level), 32'd16);
        chk("full_flag", 32'(full_out), 32'd1);
        chk("full_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain(1'b0);
        chk("empty_level", 32'(level), 32'd0);
        chk("empty_full", 32'(full_out), 32'd0);

        for (int p = 0; p < 4; p++) begin
            mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 3)) tick();
                push(rand_word(1'b0), 1'b1);
            end
            drain(1'b1);
        end

        mode      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(rand_word(1'b1), 1'b1);
        tick();
        d0 = done_cnt;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_full", 32'(full_out), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_done", 32'(done_sig), 32'd0);
        chk("mid_dz", 32'(div_zero), 32'd0);
        chk("mid_result", 32'(result), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("post_level", 32'(level), 32'd0);
        chk("post_done", 32'(done_cnt - d0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_divmul_engine.md
FIFO_DIVMUL_ENGINE -- requirements
Module: fifo_divmul_engine

Interface
REQ-001 Parameter W, default 8, signed operand width (4..16).
REQ-002 Parameter DEPTH, default 16, FIFO depth in words, power of two >= 2; AW = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 write_req  input  1  push fifo_write_data this cycle.
REQ-006 fifo_write_data  input  2W  {dividend[2W-1:W], divisor[W-1:0]}, both two's complement.
REQ-007 full_out  output  1  FIFO holds DEPTH words.
REQ-008 level  output  AW+1  current FIFO occupancy, 0..DEPTH.
REQ-009 mode  input  1  0 = result is q*r product; 1 = result is {q,r} packed.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_valid  output  1  result, div_zero valid.
REQ-012 result  output  2W  computed result per mode.
REQ-013 div_zero  output  1  current result came from a zero divisor.
REQ-014 done_sig  output  1  one-cycle pulse when out_valid && out_ready.

Function
REQ-015 Write accepted when write_req=1 and full_out=0; when full_out=1 the word is dropped and level is unchanged, even if a pop occurs that cycle.
REQ-016 Simultaneous accepted push and pop leaves level unchanged; read/write pointers wrap modulo DEPTH.
REQ-017 FSM states: IDLE, LOAD, DIV, MUL, OUT.
REQ-018 IDLE: if level != 0, pop one word (registered read), go LOAD; else stay.
REQ-019 LOAD: capture dividend, divisor, mode; if divisor == 0 go MUL with q = all-ones, r = dividend, div_zero flag set; else form magnitudes, go DIV.
REQ-020 DIV: unsigned restoring division on magnitudes, one quotient bit per cycle, exactly W cycles, then MUL.
REQ-021 Sign rules: quotient truncates toward zero; q negative iff operand signs differ; r takes dividend's sign; q and r are W bits.
REQ-022 Overflow: dividend = -2^(W-1), divisor = -1 yields q = -2^(W-1) (wrapped), r = 0, div_zero = 0.
REQ-023 MUL: mode 0 result = signed q*r, full 2W bits exact; mode 1 result = {q, r}; go OUT.
REQ-024 OUT: out_valid = 1, result and div_zero held stable until out_ready = 1; on that edge done_sig pulses, return to IDLE.
REQ-025 Latency (nonzero divisor): out_valid asserts W+3 cycles after the IDLE pop edge; zero divisor: 3 cycles.
REQ-026 FIFO continues accepting writes during LOAD/DIV/MUL/OUT; mode changes after LOAD do not affect the operation in flight.
REQ-027 Back-to-back: with out_ready held 1 and FIFO non-empty, next pop occurs the cycle after done_sig.

Reset
REQ-028 rst_n low asynchronously forces: FSM IDLE, FIFO empty (level 0, full_out 0), out_valid 0, done_sig 0, div_zero 0, result 0.
REQ-029 Reset mid-operation discards the in-flight operation and all FIFO contents; no done_sig is produced for it.
REQ-030 First pop may occur on the second rising edge after rst_n deasserts.

Verification (W=8, DEPTH=16)
REQ-031 Push {45,2}, {23,12}, mode 0, out_ready=1 -> results 16'd22 then 16'd11, two done_sig pulses, div_zero 0.
REQ-032 Push {15,-6 (8'hFA)} mode 0 -> result 16'hFFFA (-6); repeat mode 1 -> result 16'hFE03.
REQ-033 Push {7,0} mode 1 -> div_zero 1, result 16'hFF07, out_valid 3 cycles after pop.
REQ-034 Push {-128,-1} mode 1 -> result 16'h8000, div_zero 0.
REQ-035 out_ready=0, push 18 words -> engine holds 1 in OUT, level reaches 16, full_out 1, 18th dropped; release out_ready -> 17 results in order.
REQ-036 Assert rst_n low during DIV with 3 words queued -> all outputs reset immediately, level 0, no later out_valid without new writes.
